load_store_unit: RTL and testbench

//  Initiator side of the data-memory port. Takes one load/store request at a time from the core
//  (RV32 funct3 encoding) and drives the word-wide memory port: mem_WE, mem_A, mem_WD, mem_RD.

---
 rtl/load_store_unit.sv | 249 ++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one RV32 load/store at a time against a word-wide, combinational-read data memory.
// Optional statistics counters are built in when the macro LSU_STATS_EN is defined.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 65536,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic             resp_err,
  output logic [31:0]      resp_rdata,
  output logic             mem_WE,
  output logic [31:0]      mem_A,
  output logic [31:0]      mem_WD,
  input  logic [31:0]      mem_RD
`ifdef LSU_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_loads,
  output logic [CNT_W-1:0] stat_stores,
  output logic [CNT_W-1:0] stat_errs
`endif
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        req_err;
  logic [32:0] req_size;
  logic [32:0] req_end;
  logic [31:0] load_shifted;
  logic [31:0] load_value;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data;
  logic [31:0] write_word;

  assign accept = req_valid && (state_q == S_IDLE);

  // Request legality is decided at accept so an illegal request never reaches the memory port.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    req_size = 33'd1;
    case (req_funct3)
      F3_H, F3_HU: req_size = 33'd2;
      F3_W:        req_size = 33'd4;
      default:     req_size = 33'd1;
    endcase
    req_end = {1'b0, req_addr} + req_size;
    req_err = 1'b0;
    if (!(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})) req_err = 1'b1;
    if ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) req_err = 1'b1;
    if (req_funct3 == F3_W && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if (req_we && (req_funct3 == F3_BU || req_funct3 == F3_HU)) req_err = 1'b1;
    if (req_end > 33'(MEM_BYTES)) req_err = 1'b1;
  end

  // Load lane extraction and extension.
  always_comb begin
    load_shifted = mem_RD >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      F3_B:    load_value = {{24{load_shifted[7]}}, load_shifted[7:0]};
      F3_BU:   load_value = {24'd0, load_shifted[7:0]};
      F3_H:    load_value = {{16{load_shifted[15]}}, load_shifted[15:0]};
      F3_HU:   load_value = {16'd0, load_shifted[15:0]};
      default: load_value = mem_RD;
    endcase
  end

  // Store merge: only the selected byte lanes take new data, the rest come from the captured word.
  always_comb begin
    case (funct3_q)
      F3_B: begin
        lane_mask = 4'b0001 << addr_q[1:0];
        lane_data = {4{wdata_q[7:0]}};
      end
      F3_H: begin
        lane_mask = 4'b0011 << addr_q[1:0];
        lane_data = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_mask = 4'b1111;
        lane_data = wdata_q;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      write_word[8*i +: 8] = lane_mask[i] ? lane_data[8*i +: 8] : merge_q[8*i +: 8];
    end
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_err)                state_d = S_RESP;
          else if (!req_we)           state_d = S_LOAD;
          else if (req_funct3 == F3_W) state_d = S_WRITE;
          else                        state_d = S_RMW_RD;
        end
      end
      S_LOAD:   state_d = S_RESP;
      S_RMW_RD: state_d = S_WRITE;
      S_WRITE:  state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs. The write strobe is masked by rst so a reset edge never commits a write.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_err   = err_q;
    resp_rdata = rdata_q;
    mem_WE     = (state_q == S_WRITE) && !rst;
    mem_A      = 32'd0;
    mem_WD     = 32'd0;
    if (state_q == S_LOAD || state_q == S_RMW_RD || state_q == S_WRITE) begin
      mem_A = {addr_q[31:2], 2'b00};
    end
    if (state_q == S_WRITE) mem_WD = write_word;
  end

  // Request latches, merge register and response registers.
  always_comb begin
    addr_d   = addr_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (accept) begin
      addr_d   = req_addr;
      funct3_d = req_funct3;
      wdata_d  = req_wdata;
      we_d     = req_we;
      if (req_err) begin
        err_d   = 1'b1;
        rdata_d = 32'd0;
      end
    end
    case (state_q)
      S_LOAD: begin
        err_d   = 1'b0;
        rdata_d = load_value;
      end
      S_RMW_RD: merge_d = mem_RD;
      S_WRITE: begin
        err_d   = 1'b0;
        rdata_d = 32'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= 32'd0;
      funct3_q <= 3'd0;
      wdata_q  <= 32'd0;
      we_q     <= 1'b0;
      merge_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

`ifdef LSU_STATS_EN
  logic [CNT_W-1:0] loads_q, loads_d;
  logic [CNT_W-1:0] stores_q, stores_d;
  logic [CNT_W-1:0] errs_q, errs_d;

  // Saturating per-class counters, bumped once per completed response.
  always_comb begin
    loads_d  = loads_q;
    stores_d = stores_q;
    errs_d   = errs_q;
    if (state_q == S_RESP) begin
      if (err_q) begin
        if (errs_q != '1) errs_d = errs_q + 1'b1;
      end else if (we_q) begin
        if (stores_q != '1) stores_d = stores_q + 1'b1;
      end else begin
        if (loads_q != '1) loads_d = loads_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loads_q  <= '0;
      stores_q <= '0;
      errs_q   <= '0;
    end else begin
      loads_q  <= loads_d;
      stores_q <= stores_d;
      errs_q   <= errs_d;
    end
  end

  assign stat_loads  = loads_q;
  assign stat_stores = stores_q;
  assign stat_errs   = errs_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a byte-array reference memory predicts every response.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_WE;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic [31:0] mem_RD;
`ifdef LSU_STATS_EN
  logic [15:0] stat_loads;
  logic [15:0] stat_stores;
  logic [15:0] stat_errs;
`endif

  load_store_unit #(.MEM_BYTES(65536), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_WE     (mem_WE),
    .mem_A      (mem_A),
    .mem_WD     (mem_WD),
    .mem_RD     (mem_RD)
`ifdef LSU_STATS_EN
    ,
    .stat_loads (stat_loads),
    .stat_stores(stat_stores),
    .stat_errs  (stat_errs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on posedge; the preload port is only used under reset.
  logic [31:0] dmem [0:16383];
  logic        pl_en;
  logic [13:0] pl_idx;
  logic [31:0] pl_data;

  assign mem_RD = dmem[mem_A[15:2]];

  always @(posedge clk) begin
    if (mem_WE)     dmem[mem_A[15:2]] <= mem_WD;
    else if (pl_en) dmem[pl_idx] <= pl_data;
  end

  // Reference model state.
  logic [7:0] ref_mem [0:65535];
  int n_checks;
  int n_fail;
  int m_loads, m_stores, m_errs;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    case (f3)
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 1;
    endcase
  endfunction

  function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    longint unsigned a = addr;
    int sz = acc_size(f3);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
    if (sz == 2 && addr[0]) return 1'b1;
    if (sz == 4 && addr[1:0] != 2'b00) return 1'b1;
    if (we && (f3 == 3'b100 || f3 == 3'b101)) return 1'b1;
    if (a + longint'(sz) > 64'd65536) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    logic [15:0] base = {addr[15:2], 2'b00};
    return {ref_mem[base + 16'd3], ref_mem[base + 16'd2], ref_mem[base + 16'd1], ref_mem[base]};
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v = 32'd0;
    int sz = acc_size(f3);
    for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[addr[15:0] + 16'(i)];
    if (f3 == 3'b000 && v[7])  v[31:8]  = 24'hFFFFFF;
    if (f3 == 3'b001 && v[15]) v[31:16] = 16'hFFFF;
    return v;
  endfunction

  // Issue one request starting at a negedge; ends at the negedge after the response pulse.
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd_out, output logic err_out);
    bit          e_err;
    int          e_lat;
    logic [31:0] e_rd, e_wd;
    int          we_cnt;
    int          lat;
    bit          got;
    e_err = model_err(we, f3, addr);
    e_rd  = (!we && !e_err) ? model_load(f3, addr) : 32'd0;
    e_wd  = 32'd0;
    if (we && !e_err) begin
      for (int i = 0; i < acc_size(f3); i++) ref_mem[addr[15:0] + 16'(i)] = wd[8*i +: 8];
      e_wd = ref_word(addr);
    end
    e_lat = e_err ? 1 : (!we ? 2 : (f3 == 3'b010 ? 2 : 3));
    if (e_err) m_errs++;
    else if (we) m_stores++;
    else m_loads++;

    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    we_cnt = 0;
    got    = 1'b0;
    lat    = 0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      if (mem_WE) begin
        we_cnt++;
        check("mem_A_on_write", mem_A, {addr[31:2], 2'b00});
        check("mem_WD_on_write", mem_WD, e_wd);
      end
      if (resp_valid) begin
        got = 1'b1;
        lat = k;
      end
    end
    check("resp_seen", {31'd0, got}, 32'd1);
    check("latency", lat, e_lat);
    check("resp_err", {31'd0, resp_err}, {31'd0, e_err});
    check("resp_rdata", resp_rdata, e_rd);
    check("write_count", we_cnt, (we && !e_err) ? 1 : 0);
    check("mem_A_in_resp", mem_A, 32'd0);
    if (we && !e_err) check("mem_word_after_store", dmem[addr[15:2]], ref_word(addr));
    rd_out  = resp_rdata;
    err_out = resp_err;
    @(negedge clk);
    check("resp_single_pulse", {31'd0, resp_valid}, 32'd0);
    check("resp_rdata_hold", resp_rdata, e_rd);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    m_loads    = 0;
    m_stores   = 0;
    m_errs     = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    pl_en      = 1'b0;
    pl_idx     = 14'd0;
    pl_data    = 32'd0;

    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_mem_WE", {31'd0, mem_WE}, 32'd0);
    check("rst_mem_A", mem_A, 32'd0);
    check("rst_mem_WD", mem_WD, 32'd0);

    // Preload the low and high 256-byte windows while reset holds the unit idle.
    for (int w = 0; w < 128; w++) begin
      logic [13:0] idx;
      logic [31:0] val;
      idx = (w < 64) ? 14'(w) : 14'(16384 - 128 + w);
      val = $urandom;
      pl_en   = 1'b1;
      pl_idx  = idx;
      pl_data = val;
      for (int b = 0; b < 4; b++) ref_mem[{idx, 2'b00} + 16'(b)] = val[8*b +: 8];
      @(negedge clk);
    end
    pl_en = 1'b0;
    rst   = 1'b0;
    @(negedge clk);

    // Directed cases.
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er);
    do_req(1'b0, 3'b000, 32'h13, 32'h0, rd, er);
    check("lb_0x13", rd, 32'hFFFFFFDE);
    do_req(1'b0, 3'b100, 32'h13, 32'h0, rd, er);
    check("lbu_0x13", rd, 32'h000000DE);
    do_req(1'b0, 3'b001, 32'h12, 32'h0, rd, er);
    check("lh_0x12", rd, 32'hFFFFDEAD);
    do_req(1'b1, 3'b000, 32'h11, 32'h55, rd, er);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    check("lw_after_sb", rd, 32'hDEAD55EF);
    do_req(1'b0, 3'b010, 32'h12, 32'h0, rd, er);
    check("lw_misaligned_err", {31'd0, er}, 32'd1);
    do_req(1'b1, 3'b001, 32'h13, 32'h1234, rd, er);
    do_req(1'b0, 3'b011, 32'h10, 32'h0, rd, er);
    do_req(1'b1, 3'b100, 32'h10, 32'h77, rd, er);
    check("sb_funct3_100_err", {31'd0, er}, 32'd1);
    do_req(1'b0, 3'b010, 32'hFFFC, 32'h0, rd, er);
    do_req(1'b0, 3'b010, 32'h10000, 32'h0, rd, er);
    check("lw_out_of_range_err", {31'd0, er}, 32'd1);
    do_req(1'b1, 3'b000, 32'hFFFF, 32'hA5, rd, er);
    do_req(1'b0, 3'b101, 32'hFFFE, 32'h0, rd, er);

    // Reset during the WRITE cycle of SB 0x20: no write, no response, idle afterwards.
    begin
      bit seen_we;
      seen_we    = 1'b0;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b000;
      req_addr   = 32'h20;
      req_wdata  = 32'hC3;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int k = 0; k < 6 && !seen_we; k++) begin
        @(negedge clk);
        if (mem_WE) seen_we = 1'b1;
        check("no_resp_before_abort", {31'd0, resp_valid}, 32'd0);
      end
      check("abort_reached_write", {31'd0, seen_we}, 32'd1);
      rst = 1'b1;
      #1 check("mem_WE_gated_by_rst", {31'd0, mem_WE}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      m_loads  = 0;
      m_stores = 0;
      m_errs   = 0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
      end
      check("abort_word_unchanged", dmem[8], ref_word(32'h20));
    end

    // Randomized traffic concentrated on the preloaded windows and the top-of-memory boundary.
    for (int n = 0; n < 250; n++) begin
      bit          we;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          pick;
      we = $urandom_range(0, 1) == 1;
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
                                       : (we ? 3'($urandom_range(0, 2))
                                             : 3'($urandom_range(0, 1) == 1 ? $urandom_range(0, 2)
                                                                            : $urandom_range(4, 5)));
      pick = $urandom_range(0, 9);
      if (pick < 6)       addr = 32'($urandom_range(0, 255));
      else if (pick < 9)  addr = 32'h0000FF00 + 32'($urandom_range(0, 255));
      else                addr = (pick == 9 && $urandom_range(0, 1) == 1) ? $urandom
                                                                          : 32'h0000FFF8 + 32'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) begin
        if (acc_size(f3) == 2) addr[0] = 1'b0;
        if (acc_size(f3) == 4) addr[1:0] = 2'b00;
      end
      do_req(we, f3, addr, $urandom, rd, er);
    end

`ifdef LSU_STATS_EN
    check("stat_loads", {16'd0, stat_loads}, 32'(m_loads));
    check("stat_stores", {16'd0, stat_stores}, 32'(m_stores));
    check("stat_errs", {16'd0, stat_errs}, 32'(m_errs));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
